// File: rtl/reg_bank_dump_reader_pkg.sv
// Shared definitions for the register-bank dump reader: bank geometry defaults,
// FSM state encoding and a sizing helper for the read-latency counter.
package reg_bank_dump_reader_pkg;

  localparam int NREGS_DEF = 8;
  localparam int WIDTH_DEF = 16;
  localparam int AW_DEF    = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Counter width that can hold the value RD_LAT itself.
  function automatic int cnt_w(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/reg_bank_dump_reader_rd_lat_counter.sv
// Read-latency down-counter: loaded with RD_LAT on issue, decremented while waiting;
// expire flags the cycle whose decrement brings the count to zero.
module reg_bank_dump_reader_rd_lat_counter
  import reg_bank_dump_reader_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic expire
);

  localparam int CW = cnt_w(RD_LAT);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CW'(RD_LAT);
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign expire = (cnt_q == CW'(1));

endmodule

// File: rtl/reg_bank_dump_reader.sv
// Read-side dump master for the register bank: walks first..last (with wrap), reads
// each word through the bank read port and streams it out with its index.
module reg_bank_dump_reader
  import reg_bank_dump_reader_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int WIDTH  = WIDTH_DEF,
  parameter int AW     = AW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [AW-1:0]    first_reg,
  input  logic [AW-1:0]    last_reg,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] rd_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [AW-1:0]    m_idx,
  output logic             m_last,
  output logic             busy,
  output logic             done
);

  state_e state_q, state_d;

  logic [AW-1:0]    cur_q, last_q;
  logic [WIDTH-1:0] m_data_q;
  logic [AW-1:0]    m_idx_q;
  logic             m_last_q;

  logic latch_range, cnt_load, cnt_dec, cnt_expire, capture, advance;

  function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] i);
    return AW'((int'(i) + 1) % NREGS);
  endfunction

  reg_bank_dump_reader_rd_lat_counter #(
    .RD_LAT (RD_LAT)
  ) u_rd_lat_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (cnt_load),
    .dec    (cnt_dec),
    .expire (cnt_expire)
  );

  always_comb begin
    state_d     = state_q;
    latch_range = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    capture     = 1'b0;
    advance     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          latch_range = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_load = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_expire) begin
          capture = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (m_ready) begin
          if (m_last_q) begin
            state_d = S_DONE;
          end else begin
            advance = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Abort beats any handshake in flight; in IDLE it is ignored so start wins.
    if (abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      capture  = 1'b0;
      advance  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      if (latch_range) begin
        cur_q  <= first_reg;
        last_q <= last_reg;
      end else if (advance) begin
        cur_q  <= next_idx(cur_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data_q <= '0;
      m_idx_q  <= '0;
      m_last_q <= 1'b0;
    end else if (capture) begin
      m_data_q <= rd_data;
      m_idx_q  <= cur_q;
      m_last_q <= (cur_q == last_q);
    end
  end

  assign rd_en   = (state_q == S_ISSUE);
  assign rd_addr = cur_q;
  assign m_valid = (state_q == S_HOLD);
  assign m_data  = m_data_q;
  assign m_idx   = m_idx_q;
  assign m_last  = m_last_q && (state_q == S_HOLD);
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_reg_bank_dump_reader.sv
// Bench for reg_bank_dump_reader: bank model with read latency, expected-word queue
// built from each accepted range, and a per-cycle compare against that queue.
module tb_reg_bank_dump_reader;

  localparam int NREGS  = 8;
  localparam int WIDTH  = 16;
  localparam int AW     = 3;
  localparam int RD_LAT = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [AW-1:0]    first_reg = '0;
  logic [AW-1:0]    last_reg = '0;
  logic             m_ready = 1'b1;
  logic [WIDTH-1:0] rd_data;
  logic             rd_en, m_valid, m_last, busy, done;
  logic [AW-1:0]    rd_addr, m_idx;
  logic [WIDTH-1:0] m_data;

  always #5 clk = ~clk;

  reg_bank_dump_reader #(
    .NREGS(NREGS), .WIDTH(WIDTH), .AW(AW), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .first_reg(first_reg), .last_reg(last_reg),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx),
    .m_last(m_last), .busy(busy), .done(done)
  );

  // Bank: data appears RD_LAT cycles after the rd_en sample, junk otherwise.
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] pipe_d [RD_LAT];
  logic             pipe_v [RD_LAT];
  logic [WIDTH-1:0] junk;

  initial begin
    for (int i = 0; i < RD_LAT; i++) begin
      pipe_v[i] = 1'b0;
      pipe_d[i] = '0;
    end
    junk = '0;
  end

  always @(posedge clk) begin
    pipe_v[0] <= rd_en;
    pipe_d[0] <= regs[rd_addr];
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
    junk <= WIDTH'($urandom);
  end

  assign rd_data = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : junk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct { logic [AW-1:0] idx; logic last; } word_t;
  typedef struct { logic [AW-1:0] idx; logic [WIDTH-1:0] data; logic last; int cyc; } log_t;

  word_t q[$];
  log_t  log_q[$];
  bit    exp_busy = 0, exp_done = 0;
  int    cyc = 0, last_hs_cyc = 0, rd_since_hs = 0;
  bit    ready_steady = 0, prev_stall = 0;
  logic [WIDTH-1:0] prev_data;
  logic [AW-1:0]    prev_idx;
  logic             prev_last;

  // Compare process: inputs are stable here and sampled at the coming posedge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      check("reset_outputs", {rd_en, rd_addr, m_valid, m_data, m_idx, m_last, busy, done}, '0);
      q.delete();
      exp_busy   = 0;
      exp_done   = 0;
      prev_stall = 0;
    end else begin
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
      check("rd_en_with_valid", rd_en & m_valid, 0);
      if (!exp_busy) check("idle_quiet", {m_valid, rd_en, m_last}, 0);
      if (rd_en) begin
        if (q.size() == 0) check("rd_en_unexpected", rd_en, 0);
        else check("rd_addr", rd_addr, q[0].idx);
        rd_since_hs++;
        check("one_read_per_word", rd_since_hs <= 1, 1);
      end
      if (prev_stall)
        check("hold_stable", {m_valid, m_data, m_idx, m_last}, {1'b1, prev_data, prev_idx, prev_last});
      if (!m_ready) ready_steady = 0;

      if (!exp_busy) begin
        if (start) begin
          int n;
          n = ((int'(last_reg) - int'(first_reg) + NREGS) % NREGS) + 1;
          for (int k = 0; k < n; k++) begin
            word_t w;
            w.idx  = AW'((int'(first_reg) + k) % NREGS);
            w.last = (k == n - 1);
            q.push_back(w);
          end
          exp_busy     = 1;
          last_hs_cyc  = cyc;
          ready_steady = 1;
          rd_since_hs  = 0;
        end
      end else if (abort) begin
        exp_busy = 0;
        exp_done = 0;
        q.delete();
      end else if (exp_done) begin
        exp_busy = 0;
        exp_done = 0;
      end else if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          check("handshake_unexpected", m_valid, 0);
        end else begin
          log_t l;
          check("m_idx", m_idx, q[0].idx);
          check("m_data", m_data, regs[q[0].idx]);
          check("m_last", m_last, q[0].last);
          if (ready_steady) check("word_spacing", cyc - last_hs_cyc, RD_LAT + 2);
          l.idx = m_idx; l.data = m_data; l.last = m_last; l.cyc = cyc;
          log_q.push_back(l);
          if (q[0].last) exp_done = 1;
          void'(q.pop_front());
        end
        last_hs_cyc  = cyc;
        ready_steady = 1;
        rd_since_hs  = 0;
      end
      prev_stall = m_valid && !m_ready && !abort;
    end
    prev_data = m_data;
    prev_idx  = m_idx;
    prev_last = m_last;
  end

  // Downstream ready: 0 = always ready, 1 = random, 2 = stall idx3 for 5 cycles.
  int ready_mode = 0;
  initial begin
    int bp_cnt;
    bp_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: m_ready = ($urandom % 3) != 0;
        2: begin
          if (m_valid && (m_idx == 3'd3) && (bp_cnt < 5)) begin
            m_ready = 1'b0;
            bp_cnt++;
          end else begin
            m_ready = 1'b1;
          end
        end
        default: m_ready = 1'b1;
      endcase
      if (ready_mode != 2) bp_cnt = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [AW-1:0] f, input logic [AW-1:0] l);
    first_reg = f;
    last_reg  = l;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    if (busy) check({name, "_timeout"}, busy, 0);
  endtask

  task automatic run_dump(input logic [AW-1:0] f, input logic [AW-1:0] l);
    log_q.delete();
    pulse_start(f, l);
    wait_idle("dump", 400);
    tick();
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) regs[i] = WIDTH'(16'h1000 + i);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Full dump at full rate.
    ready_mode = 0;
    run_dump(3'd0, 3'd7);
    check("full_count", log_q.size(), 8);
    if (log_q.size() == 8) begin
      check("full_first", {log_q[0].idx, log_q[0].data}, {3'd0, 16'h1000});
      check("full_last", {log_q[7].idx, log_q[7].data, log_q[7].last}, {3'd7, 16'h1007, 1'b1});
      check("full_not_last", log_q[6].last, 0);
      check("full_rate", log_q[1].cyc - log_q[0].cyc, 3);
    end

    // Wrapped range.
    run_dump(3'd6, 3'd1);
    check("wrap_count", log_q.size(), 4);
    if (log_q.size() == 4) begin
      check("wrap_idx", {log_q[0].idx, log_q[1].idx, log_q[2].idx, log_q[3].idx},
            {3'd6, 3'd7, 3'd0, 3'd1});
      check("wrap_lasts", {log_q[0].last, log_q[1].last, log_q[2].last, log_q[3].last}, 4'b0001);
    end

    // Backpressure on idx3.
    ready_mode = 2;
    run_dump(3'd0, 3'd5);
    ready_mode = 0;
    check("bp_count", log_q.size(), 6);
    if (log_q.size() == 6) begin
      check("bp_idx3", log_q[3].idx, 3);
      check("bp_stall_gap", log_q[3].cyc - log_q[2].cyc, 8);
      check("bp_resume_gap", log_q[4].cyc - log_q[3].cyc, 3);
    end

    // Abort while idx2 is held with ready high.
    log_q.delete();
    pulse_start(3'd0, 3'd7);
    begin
      int n;
      n = 0;
      while (!(m_valid && m_idx == 3'd2) && n < 50) begin
        tick();
        n++;
      end
      check("abort_reach_idx2", m_valid && m_idx == 3'd2, 1);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", {busy, m_valid, rd_en, m_last}, 4'b0000);
    check("abort_words", log_q.size(), 2);
    repeat (4) tick();

    // Single-word range.
    run_dump(3'd5, 3'd5);
    check("single_count", log_q.size(), 1);
    if (log_q.size() == 1) check("single_word", {log_q[0].idx, log_q[0].last}, {3'd5, 1'b1});

    // Start while busy is ignored.
    log_q.delete();
    pulse_start(3'd2, 3'd4);
    repeat (2) tick();
    pulse_start(3'd7, 3'd7);
    wait_idle("busy_start", 400);
    tick();
    check("busy_start_count", log_q.size(), 3);
    if (log_q.size() == 3)
      check("busy_start_idx", {log_q[0].idx, log_q[1].idx, log_q[2].idx}, {3'd2, 3'd3, 3'd4});

    // Randomized dumps with random ready, aborts and ignored restarts.
    ready_mode = 1;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NREGS; i++) regs[i] = WIDTH'($urandom);
      pulse_start(AW'($urandom), AW'($urandom));
      for (int k = 0; k < 400 && busy; k++) begin
        abort     = ($urandom % 60) == 0;
        start     = ($urandom % 8) == 0;
        first_reg = AW'($urandom);
        last_reg  = AW'($urandom);
        tick();
      end
      abort = 1'b0;
      start = 1'b0;
      if (busy) check("random_timeout", busy, 0);
      tick();
    end
    ready_mode = 0;

    // Asynchronous reset in the middle of a read wait.
    for (int i = 0; i < NREGS; i++) regs[i] = WIDTH'(16'h1000 + i);
    pulse_start(3'd0, 3'd7);
    begin
      int n;
      n = 0;
      while (!rd_en && n < 20) begin
        tick();
        n++;
      end
      check("reset_reach_read", rd_en, 1);
    end
    tick();
    #2 rst_n = 1'b0;
    #1 check("async_reset", {rd_en, rd_addr, m_valid, m_data, m_idx, m_last, busy, done}, '0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", {busy, done, m_valid}, 3'b000);
    run_dump(3'd1, 3'd2);
    check("post_reset_dump", log_q.size(), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
